// File: rtl/act_unit_stream.sv
// Multi-lane streaming activation + rounding requantisation stage.
// Two-stage valid/ready pipeline with a sticky saturation event counter.
module act_unit_stream #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned INPUT_WIDTH  = 20,
    parameter int unsigned OUTPUT_WIDTH = 8,
    parameter int unsigned LEAK_SHIFT   = 3,
    parameter int unsigned SHIFT_W      = 5,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CHANNELS*INPUT_WIDTH-1:0]  in_data,
    input  logic [1:0]                       mode,
    input  logic [SHIFT_W-1:0]               shift_amt,
    input  logic [INPUT_WIDTH-1:0]           clip_max,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CHANNELS*OUTPUT_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]                 sat_count,
    input  logic                             sat_clr
);

    localparam int unsigned IW     = INPUT_WIDTH;
    localparam int unsigned OW     = OUTPUT_WIDTH;
    localparam int unsigned RW     = IW + 1;
    localparam int unsigned NSAT_W = $clog2(CHANNELS + 1);
    localparam int unsigned SUM_W  = ((CNT_W > NSAT_W) ? CNT_W : NSAT_W) + 1;

    localparam logic signed [RW-1:0] OUT_MAX = RW'(2 ** (OW - 1) - 1);
    localparam logic signed [RW-1:0] OUT_MIN = RW'(-(2 ** (OW - 1)));
    localparam logic [CNT_W-1:0]     CNT_MAX = '1;

    logic                     s1_valid;
    logic signed [RW-1:0]     s1_r [CHANNELS];
    logic [SHIFT_W-1:0]       s1_shift;
    logic [NSAT_W-1:0]        s2_nsat;

    logic                     adv1;
    logic                     adv2;
    logic signed [RW-1:0]     r_next [CHANNELS];
    logic signed [RW-1:0]     q_full [CHANNELS];
    logic [CHANNELS*OW-1:0]   q_next;
    logic [NSAT_W-1:0]        nsat_next;
    logic [SUM_W-1:0]         sat_sum;
    logic [CNT_W-1:0]         sat_next;

    // Activation followed by the half-LSB rounding offset, one bit wider than the input.
    function automatic logic signed [RW-1:0] act_round(
        input logic signed [IW-1:0] x,
        input logic [1:0]           m,
        input logic [SHIFT_W-1:0]   sh,
        input logic signed [IW-1:0] cm
    );
        logic signed [IW-1:0] a;
        logic signed [RW-1:0] rnd;
        case (m)
            2'b01:   a = (x < 0) ? '0 : x;
            2'b10:   a = (x < 0) ? (x >>> LEAK_SHIFT) : x;
            2'b11:   a = ((x < 0) || (cm < 0)) ? '0 : ((x > cm) ? cm : x);
            default: a = x;
        endcase
        rnd = (sh == '0) ? '0 : $signed(RW'(1) << (sh - SHIFT_W'(1)));
        return $signed(RW'(a)) + rnd;
    endfunction

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1 | rst;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            r_next[i] = act_round($signed(in_data[i*IW +: IW]), mode, shift_amt,
                                  $signed(clip_max));
        end
    end

    // Stage 2: arithmetic shift, clamp to the output range, count clamped lanes.
    always_comb begin
        q_next    = '0;
        nsat_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            q_full[i] = s1_r[i] >>> s1_shift;
            if (q_full[i] > OUT_MAX) begin
                q_next[i*OW +: OW] = OW'(OUT_MAX);
                nsat_next          = nsat_next + NSAT_W'(1);
            end else if (q_full[i] < OUT_MIN) begin
                q_next[i*OW +: OW] = OW'(OUT_MIN);
                nsat_next          = nsat_next + NSAT_W'(1);
            end else begin
                q_next[i*OW +: OW] = OW'(q_full[i]);
            end
        end
    end

    assign sat_sum  = SUM_W'(sat_count) + SUM_W'(s2_nsat);
    assign sat_next = (sat_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sat_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_r      <= '{default: '0};
            s1_shift  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            s2_nsat   <= '0;
            sat_count <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_r     <= r_next;
                    s1_shift <= shift_amt;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= q_next;
                    s2_nsat  <= nsat_next;
                end
            end
            if (sat_clr) begin
                sat_count <= '0;
            end else if (out_valid && out_ready) begin
                sat_count <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_act_unit_stream.sv
// Bench for act_unit_stream: vector table, directed corner sequences and a
// randomized stream scored against an arithmetic reference model.
module tb_act_unit_stream;

    localparam int unsigned IW = 20;
    localparam int unsigned OW = 8;
    localparam int unsigned CH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, sat_clr;
    logic [CH*IW-1:0] in_data;
    logic [1:0]       mode;
    logic [4:0]       shift_amt;
    logic [IW-1:0]    clip_max;
    logic [CH*OW-1:0] out_data;
    logic [15:0]      sat_count;

    logic             in_valid2, in_ready2, out_valid2, out_ready2, sat_clr2;
    logic [CH*IW-1:0] in_data2;
    logic [CH*OW-1:0] out_data2;
    logic [1:0]       sat_count2;

    always #5 clk = ~clk;

    act_unit_stream dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .shift_amt(shift_amt), .clip_max(clip_max),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_count(sat_count), .sat_clr(sat_clr)
    );

    act_unit_stream #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .mode(2'b00), .shift_amt(5'd0), .clip_max(20'd0),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .sat_count(sat_count2), .sat_clr(sat_clr2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [79:0] act, input logic [79:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic void ref_beat(input logic [79:0] din, input logic [1:0] m,
                                     input logic [4:0] sh, input logic [19:0] cm,
                                     output logic [31:0] dout, output int nsat);
        longint x, a, q, c;
        c    = longint'($signed(cm));
        nsat = 0;
        dout = '0;
        for (int i = 0; i < 4; i++) begin
            x = longint'($signed(din[i*20 +: 20]));
            case (m)
                2'd1:    a = (x < 0) ? 0 : x;
                2'd2:    a = (x < 0) ? fdiv(x, 8) : x;
                2'd3:    a = (c < 0) ? 0 : ((x < 0) ? 0 : ((x > c) ? c : x));
                default: a = x;
            endcase
            if (sh != 0) a = a + (longint'(1) << (sh - 1));
            q = fdiv(a, longint'(1) << sh);
            if (q > 127) begin q = 127; nsat++; end
            else if (q < -128) begin q = -128; nsat++; end
            dout[i*8 +: 8] = 8'(q);
        end
    endfunction

    function automatic logic [79:0] pk_in(input int a, input int b, input int c, input int d);
        logic [79:0] r;
        r = {20'(d), 20'(c), 20'(b), 20'(a)};
        return r;
    endfunction

    function automatic logic [31:0] pk_out(input int a, input int b, input int c, input int d);
        logic [31:0] r;
        r = {8'(d), 8'(c), 8'(b), 8'(a)};
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    typedef struct { logic [31:0] data; int nsat; } exp_t;
    exp_t        expq[$];
    int          exp_sat   = 0;
    int          acc_count = 0;
    bit          mon_en    = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        exp_t e;
        int   n;
        if (mon_en) begin
            if (rst) begin
                expq.delete();
                exp_sat    = 0;
                prev_stall = 0;
            end else begin
                n = 0;
                check(sat_count == 16'(exp_sat), "sat_count", 80'(sat_count), 80'(exp_sat));
                if (prev_stall)
                    check(out_valid && (out_data == prev_data), "hold_stable",
                          {out_valid, out_data}, {1'b1, prev_data});
                if (out_valid && out_ready) begin
                    check(expq.size() != 0, "unexpected_beat", 80'(out_data), 80'(0));
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        check(out_data == e.data, "stream_data", 80'(out_data), 80'(e.data));
                        n = e.nsat;
                    end
                end
                if (in_valid && in_ready) begin
                    ref_beat(in_data, mode, shift_amt, clip_max, e.data, e.nsat);
                    expq.push_back(e);
                    acc_count++;
                end
                exp_sat    = sat_clr ? 0 : ((exp_sat + n > 65535) ? 65535 : exp_sat + n);
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [79:0] d, input logic [1:0] m,
                             input logic [4:0] sh, input logic [19:0] cm);
        bit done;
        done     = 0;
        in_data  = d;
        mode     = m;
        shift_amt = sh;
        clip_max = cm;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check(done, "accept_timeout", 80'(done), 80'(1));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(t < 200, "drain_timeout", 80'(expq.size()), 80'(0));
    endtask

    task automatic send2(input logic [79:0] d);
        @(posedge clk); #1;
        in_valid2 = 1'b1;
        in_data2  = d;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    function automatic logic [79:0] rand_lanes();
        logic [79:0] r;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) r[i*20 +: 20] = 20'($urandom_range(0, 1200)) - 20'd600;
            else                           r[i*20 +: 20] = 20'($urandom);
        end
        return r;
    endfunction

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  sh;
        logic [19:0] clip;
        logic [79:0] din;
        logic [31:0] dexp;
        int          inc;
    } row_t;

    row_t tbl[7];
    int   run_sat;
    bit   rnd_done;

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 1; sat_clr = 0;
        in_data = '0; mode = '0; shift_amt = '0; clip_max = '0;
        in_valid2 = 0; out_ready2 = 1; sat_clr2 = 0; in_data2 = '0;

        tbl[0] = '{2'd1, 5'd0, 20'd0,      pk_in(-5, 0, 100, 200),      pk_out(0, 0, 100, 127),      1};
        tbl[1] = '{2'd2, 5'd0, 20'd0,      pk_in(-80, -7, 64, -1),      pk_out(-10, -1, 64, -1),     0};
        tbl[2] = '{2'd0, 5'd0, 20'd0,      pk_in(-300, 300, -128, 127), pk_out(-128, 127, -128, 127), 2};
        tbl[3] = '{2'd1, 5'd4, 20'd0,      pk_in(1000, 24, 7, 8),       pk_out(63, 2, 0, 1),         0};
        tbl[4] = '{2'd3, 5'd0, 20'd50,     pk_in(60, -3, 50, 49),       pk_out(50, 0, 50, 49),       0};
        tbl[5] = '{2'd3, 5'd0, 20'(-5),    pk_in(10, -10, 0, 5),        pk_out(0, 0, 0, 0),          0};
        tbl[6] = '{2'd2, 5'd2, 20'd0,      pk_in(-100, 513, -3, 0),     pk_out(-3, 127, 0, 0),       1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(in_ready == 1'b1, "in_ready_during_reset", 80'(in_ready), 80'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1;
        @(negedge clk);
        check(out_valid == 1'b0, "reset_out_valid", 80'(out_valid), 80'(0));
        check(out_data == '0, "reset_out_data", 80'(out_data), 80'(0));
        check(sat_count == '0, "reset_sat_count", 80'(sat_count), 80'(0));
        check(in_ready == 1'b1, "reset_in_ready", 80'(in_ready), 80'(1));

        // table vectors, one beat at a time with latency check
        run_sat = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            in_data = tbl[k].din; mode = tbl[k].m; shift_amt = tbl[k].sh;
            clip_max = tbl[k].clip; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check(out_valid == 1'b0, $sformatf("latency_early_%0d", k), 80'(out_valid), 80'(0));
            @(negedge clk);
            check(out_valid == 1'b1, $sformatf("latency_due_%0d", k), 80'(out_valid), 80'(1));
            check(out_data == tbl[k].dexp, $sformatf("table_data_%0d", k), 80'(out_data), 80'(tbl[k].dexp));
            run_sat += tbl[k].inc;
            @(negedge clk);
            check(sat_count == 16'(run_sat), $sformatf("table_sat_%0d", k), 80'(sat_count), 80'(run_sat));
        end

        // mode changes on back-to-back beats
        @(posedge clk); #1;
        send_beat(pk_in(-40, 90, 300, -300), 2'd1, 5'd1, 20'd60);
        send_beat(pk_in(-40, 90, 300, -300), 2'd2, 5'd1, 20'd60);
        send_beat(pk_in(-40, 90, 300, -300), 2'd3, 5'd1, 20'd60);
        send_beat(pk_in(-40, 90, 300, -300), 2'd0, 5'd1, 20'd60);
        wait_drain();

        // backpressure: 6 beats, 4 stalled cycles
        @(posedge clk); #1;
        begin
            int start_acc;
            start_acc = acc_count;
            fork
                begin
                    for (int k = 0; k < 6; k++)
                        send_beat(pk_in(37 * k - 90, 500 - 99 * k, k, -k), 2'd1, 5'd2, 20'd0);
                end
                begin
                    out_ready = 1'b0;
                    repeat (4) @(posedge clk);
                    #1;
                    check(acc_count - start_acc == 2, "stall_accepts", 80'(acc_count - start_acc), 80'(2));
                    check(in_ready == 1'b0, "stall_in_ready", 80'(in_ready), 80'(0));
                    out_ready = 1'b1;
                end
            join
            wait_drain();
            check(acc_count - start_acc == 6, "stall_total", 80'(acc_count - start_acc), 80'(6));
        end

        // reset with two beats in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_beat(pk_in(1, 2, 3, 4), 2'd0, 5'd0, 20'd0);
        send_beat(pk_in(5, 6, 7, 8), 2'd0, 5'd0, 20'd0);
        check(sat_count != '0, "sat_before_reset", 80'(sat_count), 80'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(out_valid == 1'b0, "midreset_out_valid", 80'(out_valid), 80'(0));
        check(sat_count == '0, "midreset_sat_count", 80'(sat_count), 80'(0));
        check(in_ready == 1'b1, "midreset_in_ready", 80'(in_ready), 80'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check(out_valid == 1'b0, "no_stale_beat", 80'(out_valid), 80'(0));
        end

        // narrow counter: sticks at 3, clear beats a coincident increment
        send2(pk_in(300, -300, 300, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(sat_count2 == 2'd3, "cnt2_first", 80'(sat_count2), 80'(3));
        send2(pk_in(300, -300, 0, 0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(sat_count2 == 2'd3, "cnt2_sticky", 80'(sat_count2), 80'(3));
        send2(pk_in(300, 0, 0, 0));
        begin
            int t;
            t = 0;
            @(negedge clk);
            while (!out_valid2 && t < 10) begin @(negedge clk); t++; end
            check(out_valid2 == 1'b1, "cnt2_out_valid", 80'(out_valid2), 80'(1));
            sat_clr2 = 1'b1;
            @(posedge clk); #1;
            sat_clr2 = 1'b0;
            @(negedge clk);
            check(sat_count2 == 2'd0, "cnt2_clr_priority", 80'(sat_count2), 80'(0));
        end

        // randomized stream with random backpressure and clears
        @(posedge clk); #1;
        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [19:0] cm;
                    if ($urandom_range(0, 9) == 0) cm = 20'($urandom_range(1, 1000)) ^ 20'hFFFFF;
                    else                           cm = 20'($urandom_range(0, 2 ** 19 - 1));
                    send_beat(rand_lanes(), 2'($urandom_range(0, 3)),
                              5'($urandom_range(0, 19)), cm);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    sat_clr   = ($urandom_range(0, 19) == 0);
                end
                out_ready = 1'b1;
                sat_clr   = 1'b0;
            end
        join
        wait_drain();
        @(negedge clk);
        check(expq.size() == 0, "queue_empty", 80'(expq.size()), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
